// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries one payload word between stages with valid/ready, flush and stall/bubble counters.
// Latency: 1 cycle from input transfer to out_valid; one entry per cycle sustained in both buffer modes.
// Backpressure: SKID=0 in_ready is combinational from out_ready; SKID=1 uses a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
    parameter int              WIDTH      = 64,
    parameter int              SKID       = 1,
    parameter int              CNT_W      = 16,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             in_xfer;
    logic             out_xfer;

    // The head entry always lives in main; skid only ever holds the second entry.
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = out_valid ? main_q : BUBBLE_VAL;
    // The registered ready flop resets to 1 (EMPTY is ready) so the stage accepts
    // in the very first cycle after reset; rst gating keeps it low during reset.
    assign in_ready   = (SKID != 0) ? (in_rdy_q & !rst)
                                    : (!rst & (out_ready | !out_valid));
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    // Next-state for occupancy and payload storage; flush overrides any move and drops the input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (SKID == 0) begin
            if (in_xfer) begin
                main_d  = in_data;
                state_d = ST_ONE;
            end else if (out_xfer) begin
                state_d = ST_EMPTY;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        if (flush) begin
            state_d = ST_EMPTY;
        end
        in_rdy_d = (state_d != ST_TWO);
    end

    // Saturating stall/bubble counters; flush does not gate them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (out_ready && !out_valid && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    // State registers; synchronous reset has priority over flush and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            in_rdy_q     <= 1'b1;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            in_rdy_q     <= in_rdy_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule
